// File: rtl/matrix_job_sequencer.sv
// matrix_job_sequencer
//   Queues matrix-multiply job descriptors from a host and issues them one at
//   a time to a matrix engine using a start/finished handshake.
//
// Optional feature: define MATRIX_SEQ_WDT_EN to enable the job watchdog.
//   The watchdog aborts a job that has run for WDT_LIMIT cycles, raises a
//   sticky o_timeout and parks the sequencer in HALT until i_clr.
//
// Parameters
//   DEPTH      job FIFO depth (power of two, 2..16)
//   WDT_LIMIT  watchdog cycle limit (watchdog builds only)
// Ports
//   i_clk, i_rst_n                clock, async active-low reset
//   i_cmd_valid / o_cmd_ready     host job push handshake
//   i_cmd_rows/cols/scols         job dimensions
//   o_cmd_err                     one-cycle pulse: pushed job rejected
//   o_start, o_*_size             engine start and registered job sizes
//   i_finished                    engine finished level
//   o_busy, o_done, o_job_count   status, completion pulse, completed count
//   o_level                       FIFO occupancy
//   i_clr, o_timeout              watchdog clear, sticky timeout flag
module matrix_job_sequencer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] WDT_LIMIT = 16'd60000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_rows,
    input  logic [7:0] i_cmd_cols,
    input  logic [7:0] i_cmd_scols,
    output logic       o_cmd_err,
    output logic       o_start,
    output logic [7:0] o_f_row_size,
    output logic [7:0] o_f_col_size,
    output logic [7:0] o_s_col_size,
    input  logic       i_finished,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_job_count,
    output logic [4:0] o_level,
    input  logic       i_clr,
    output logic       o_timeout
);

    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  FULL_LEVEL = 5'(DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] ASSERT    = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RELEASE   = 3'd4;
    localparam logic [2:0] HALT      = 3'd5;

    logic [2:0]    state;
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level;
    logic [15:0]   prod_rc;
    logic [15:0]   prod_cs;
    logic [15:0]   prod_rs;
    logic          job_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic          rel_cnt;
    logic          wdt_expired;
    logic          halt_exit;
    logic          timeout;

    // Job validation: no zero dimension, every pairwise product fits 256.
    assign prod_rc = {8'h00, i_cmd_rows} * {8'h00, i_cmd_cols};
    assign prod_cs = {8'h00, i_cmd_cols} * {8'h00, i_cmd_scols};
    assign prod_rs = {8'h00, i_cmd_rows} * {8'h00, i_cmd_scols};
    assign job_ok  = (i_cmd_rows != '0) && (i_cmd_cols != '0) && (i_cmd_scols != '0) &&
                     (prod_rc <= 16'd256) && (prod_cs <= 16'd256) && (prod_rs <= 16'd256);

    assign o_cmd_ready = (level != FULL_LEVEL);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign push        = accept && job_ok;
    assign pop         = (state == LOAD);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_cmd_rows, i_cmd_cols, i_cmd_scols};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            o_cmd_err <= 1'b0;
        end else begin
            o_cmd_err <= accept && !job_ok;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

`ifdef MATRIX_SEQ_WDT_EN
    logic [15:0] wdt;

    // Counter restarts on entry to ASSERT (from LOAD) and to WAIT_DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdt <= '0;
        end else if ((state == LOAD) || ((state == ASSERT) && !i_finished)) begin
            wdt <= '0;
        end else if ((state == ASSERT) || (state == WAIT_DONE)) begin
            wdt <= wdt + 16'd1;
        end
    end

    assign wdt_expired = (wdt == WDT_LIMIT - 16'd1);
    assign halt_exit   = i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout <= 1'b0;
        end else if ((((state == ASSERT) && i_finished) ||
                      ((state == WAIT_DONE) && !i_finished)) && wdt_expired) begin
            timeout <= 1'b1;
        end else if (i_clr) begin
            timeout <= 1'b0;
        end
    end
`else
    logic [16:0] unused_cfg;

    assign unused_cfg  = {i_clr, WDT_LIMIT};
    assign wdt_expired = 1'b0;
    assign halt_exit   = 1'b1;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_f_row_size <= '0;
            o_f_col_size <= '0;
            o_s_col_size <= '0;
            o_done       <= 1'b0;
            o_job_count  <= '0;
            rel_cnt      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if ((level != '0) && !timeout && i_finished) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    {o_f_row_size, o_f_col_size, o_s_col_size} <= mem[rd_ptr];
                    state <= ASSERT;
                end
                ASSERT: begin
                    if (!i_finished) begin
                        state <= WAIT_DONE;
                    end else if (wdt_expired) begin
                        state <= HALT;
                    end
                end
                WAIT_DONE: begin
                    if (i_finished) begin
                        state       <= RELEASE;
                        o_done      <= 1'b1;
                        o_job_count <= o_job_count + 8'd1;
                        rel_cnt     <= 1'b0;
                    end else if (wdt_expired) begin
                        state <= HALT;
                    end
                end
                RELEASE: begin
                    // Two cycles with start low let the engine settle back to idle.
                    if (rel_cnt) begin
                        state <= IDLE;
                    end else begin
                        rel_cnt <= 1'b1;
                    end
                end
                HALT: begin
                    if (halt_exit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_start   = (state == ASSERT) || (state == WAIT_DONE);
    assign o_busy    = (state == LOAD) || (state == ASSERT) ||
                       (state == WAIT_DONE) || (state == RELEASE);
    assign o_level   = level;
    assign o_timeout = timeout;

endmodule

// File: tb/tb_matrix_job_sequencer.sv
`timescale 1ns/1ps
module tb_matrix_job_sequencer;

`ifdef MATRIX_SEQ_WDT_EN
    localparam logic [15:0] TB_WDT = 16'd100;
`else
    localparam logic [15:0] TB_WDT = 16'd60000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_rows = '0;
    logic [7:0] cmd_cols = '0;
    logic [7:0] cmd_scols = '0;
    logic       clr = 1'b0;
    logic       cmd_ready;
    logic       cmd_err;
    logic       start;
    logic [7:0] frow;
    logic [7:0] fcol;
    logic [7:0] scol;
    logic       fin;
    logic       busy;
    logic       done;
    logic [7:0] job_count;
    logic [4:0] level;
    logic       timeout;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    logic [23:0] exp_jobs[$];
    bit          exp_err[$];

    // Engine model
    logic eng_fin_r;
    logic eng_act;
    int   eng_cnt;
    int   eng_len = 12;
    bit   hold_busy = 1'b0;
    bit   hang = 1'b0;

    assign fin = hold_busy ? 1'b0 : eng_fin_r;

    always #5 clk = ~clk;

    matrix_job_sequencer #(.DEPTH(4), .WDT_LIMIT(TB_WDT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_rows(cmd_rows), .i_cmd_cols(cmd_cols), .i_cmd_scols(cmd_scols),
        .o_cmd_err(cmd_err),
        .o_start(start), .o_f_row_size(frow), .o_f_col_size(fcol), .o_s_col_size(scol),
        .i_finished(fin),
        .o_busy(busy), .o_done(done), .o_job_count(job_count), .o_level(level),
        .i_clr(clr), .o_timeout(timeout)
    );

    // Drops finished one cycle after seeing start, raises it after eng_len cycles,
    // then waits for start to fall before accepting the next job.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_fin_r <= 1'b1;
            eng_act   <= 1'b0;
            eng_cnt   <= 0;
        end else if (!eng_act) begin
            if (start) begin
                eng_act   <= 1'b1;
                eng_fin_r <= 1'b0;
                eng_cnt   <= 0;
            end
        end else if (!eng_fin_r) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt >= eng_len - 1 && !hang) eng_fin_r <= 1'b1;
        end else if (!start) begin
            eng_act <= 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard
    bit   accepted = 1'b0;
    logic prev_start = 1'b0;

    always @(posedge clk) accepted <= rst_n && cmd_valid && cmd_ready;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (accepted) begin
                if (exp_err.size() == 0) check("accept_unexpected", 1, 0);
                else check("cmd_err", cmd_err, exp_err.pop_front());
            end else if (cmd_err) begin
                check("cmd_err_spurious", cmd_err, 0);
            end
            if (start && !prev_start) begin
                if (exp_jobs.size() == 0) check("start_unexpected", 1, 0);
                else check("job_sizes", {frow, fcol, scol}, exp_jobs.pop_front());
            end
            prev_start = start;
            if (done) begin
                done_seen++;
                check("job_count", job_count, done_seen & 255);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_job(input logic [7:0] r, input logic [7:0] c, input logic [7:0] s,
                            input bit good);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rows = r;
        cmd_cols = c;
        cmd_scols = s;
        exp_err.push_back(!good);
        if (good) exp_jobs.push_back({r, c, s});
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("push_ready_timeout", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || level != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy || level != 0) check(nm, {busy, 3'b0, level}, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_count", job_count, 0);
        check("rst_done_err", {done, cmd_err, timeout}, 0);
        check("rst_sizes", {frow, fcol, scol}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job, start width and completion
        push_job(8'd2, 8'd3, 8'd2, 1);
        n = 0;
        while (!start && n < 20) begin @(negedge clk); n++; end
        check("t1_start_seen", start, 1);
        n = 0;
        while (start && n < 100) begin n++; @(negedge clk); end
        check("t1_start_width", n, 14);
        wait_idle("t1_idle");
        check("t1_job_count", job_count, 1);
        check("t1_done_seen", done_seen, 1);
        check("t1_sizes_held", {frow, fcol, scol}, 24'h020302);

        // Rejected jobs, plus accepted boundaries
        push_job(8'd0, 8'd4, 8'd4, 0);
        push_job(8'd16, 8'd17, 8'd1, 0);
        push_job(8'd255, 8'd1, 8'd2, 0);
        repeat (3) @(negedge clk);
        check("t2_level", level, 0);
        check("t2_no_start", {start, busy}, 0);
        check("t2_done_seen", done_seen, 1);
        push_job(8'd16, 8'd16, 8'd16, 1);
        wait_idle("t3_idle");
        push_job(8'd1, 8'd255, 8'd1, 1);
        wait_idle("t3b_idle");
        check("t3_done_seen", done_seen, 3);

        // Fill FIFO while engine reports busy, then drain in order
        eng_len = 3;
        hold_busy = 1'b1;
        push_job(8'd1, 8'd2, 8'd3, 1);
        push_job(8'd4, 8'd5, 8'd6, 1);
        push_job(8'd7, 8'd8, 8'd9, 1);
        push_job(8'd10, 8'd11, 8'd12, 1);
        check("t4_full_ready", cmd_ready, 0);
        check("t4_full_level", level, 4);
        check("t4_no_start", start, 0);
        hold_busy = 1'b0;
        push_job(8'd13, 8'd14, 8'd15, 1);
        wait_idle("t4_idle");
        check("t4_done_seen", done_seen, 8);

        // Reset during WAIT_DONE with two jobs queued
        eng_len = 40;
        push_job(8'd3, 8'd3, 8'd3, 1);
        push_job(8'd4, 8'd4, 8'd4, 1);
        push_job(8'd5, 8'd5, 8'd5, 1);
        n = 0;
        while (!(start && !fin) && n < 50) begin @(negedge clk); n++; end
        check("t5_in_wait", {start, fin}, 2'b10);
        check("t5_level_before", level, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_outs", {start, busy, done, cmd_err, timeout}, 0);
        check("t5_rst_level", level, 0);
        check("t5_rst_count", job_count, 0);
        check("t5_rst_sizes", {frow, fcol, scol}, 0);
        exp_jobs.delete();
        done_seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_done", done_seen, 0);
        check("t5_quiet", {start, busy, level}, 0);

        eng_len = 4;
        push_job(8'd5, 8'd5, 8'd5, 1);
        wait_idle("t6_idle");
        check("t6_job_count", job_count, 1);

`ifdef MATRIX_SEQ_WDT_EN
        // Watchdog: engine never finishes
        hang = 1'b1;
        push_job(8'd6, 8'd6, 8'd6, 1);
        push_job(8'd7, 8'd7, 8'd7, 1);
        n = 0;
        while (!start && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!timeout && n < 300) begin n++; @(negedge clk); end
        check("wdt_window", (n >= 95 && n <= 110), 1);
        check("wdt_state", {timeout, start, busy}, 3'b100);
        repeat (20) @(negedge clk);
        check("wdt_held", {timeout, start, level}, {1'b1, 1'b0, 5'd1});
        hang = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("wdt_cleared", timeout, 0);
        wait_idle("wdt_idle");
        check("wdt_done_seen", done_seen, 2);
`endif

        check("final_jobs_left", exp_jobs.size(), 0);
        check("final_err_left", exp_err.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
